// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer: Tuse/Tnew data-hazard compare plus a mult/div busy counter; req overrides all stalls.
// Optional build macro STALL_STATS_EN adds a 32-bit cumulative stall-cycle counter on stall_cnt.
module pipe_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        req,
    output logic        stall,
    output logic        D_en,
    output logic        F_en,
    output logic        E_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic {IDLE, MDBUSY} state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    state_t     state_q, state_d;
    logic [3:0] busy_cnt_q, busy_cnt_d;
    logic       stall_rs, stall_rt, stall_md;

    // $0 is hardwired to zero, so it can never be a hazard source.
    assign stall_rs = (D_rs_addr != 5'd0) &&
                      (((E_wa == D_rs_addr) && (E_tnew > D_tuse_rs)) ||
                       ((M_wa == D_rs_addr) && (M_tnew > D_tuse_rs)));
    assign stall_rt = (D_rt_addr != 5'd0) &&
                      (((E_wa == D_rt_addr) && (E_tnew > D_tuse_rt)) ||
                       ((M_wa == D_rt_addr) && (M_tnew > D_tuse_rt)));

    assign md_busy  = ~reset && (busy_cnt_q != 4'd0);
    assign stall_md = D_is_md && (md_busy || E_md_start);
    assign stall    = ~reset && ~req && (stall_rs || stall_rt || stall_md);
    assign D_en     = ~stall;
    assign F_en     = ~stall;
    assign E_clr    = stall;

    // A flushed start is dropped; a start while busy reloads; req never aborts a running op.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        if (E_md_start && !req) begin
            state_d    = MDBUSY;
            busy_cnt_d = E_md_div ? DIV_LD : MULT_LD;
        end else if (state_q == MDBUSY) begin
            if (busy_cnt_q <= 4'd1) begin
                state_d    = IDLE;
                busy_cnt_d = 4'd0;
            end else begin
                busy_cnt_d = busy_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= 32'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by random traffic against a reference model.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div, req;
    logic        stall, D_en, F_en, E_clr, md_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining busy cycles of the MD unit and the stall tally.
    int          md_left = 0;
    logic [31:0] stall_tally = 32'd0;
    logic        exp_stall_last;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_div(E_md_div), .req(req),
        .stall(stall), .D_en(D_en), .F_en(F_en), .E_clr(E_clr),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit reads_pending(input logic [4:0] r, input logic [1:0] tuse);
        bit pend;
        pend = 1'b0;
        if (r != 0) begin
            if (E_wa == r && int'(E_tnew) > int'(tuse)) pend = 1'b1;
            if (M_wa == r && int'(M_tnew) > int'(tuse)) pend = 1'b1;
        end
        return pend;
    endfunction

    // Compare every output against the model mid-cycle, then advance the model across the next edge.
    task automatic step(input string tag);
        bit exp_busy, exp_st;
        @(negedge clk);
        exp_busy = !reset && (md_left > 0);
        exp_st   = !reset && !req &&
                   (reads_pending(D_rs_addr, D_tuse_rs) || reads_pending(D_rt_addr, D_tuse_rt) ||
                    (D_is_md && (exp_busy || E_md_start)));
        exp_stall_last = exp_st;
        chk({tag, ".stall"},   32'(stall),   32'(exp_st));
        chk({tag, ".D_en"},    32'(D_en),    32'(!exp_st));
        chk({tag, ".F_en"},    32'(F_en),    32'(!exp_st));
        chk({tag, ".E_clr"},   32'(E_clr),   32'(exp_st));
        chk({tag, ".md_busy"}, 32'(md_busy), 32'(exp_busy));
`ifdef STALL_STATS_EN
        chk({tag, ".stall_cnt"}, stall_cnt, stall_tally);
`else
        chk({tag, ".stall_cnt"}, stall_cnt, 32'h0);
`endif
        if (reset) begin
            md_left     = 0;
            stall_tally = 32'd0;
        end else begin
            if (exp_st) stall_tally = stall_tally + 32'd1;
            if (E_md_start && !req) md_left = E_md_div ? 10 : 5;
            else if (md_left > 0)   md_left = md_left - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_rs_addr = 0; D_rt_addr = 0; D_tuse_rs = 3; D_tuse_rt = 3;
        E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
        D_is_md = 0; E_md_start = 0; E_md_div = 0; req = 0;
    endtask

    initial begin
        int n_busy, n_stall;
        idle_inputs();
        reset = 1'b1;
        #1;
        // Outputs while reset is held, even with a hazard presented.
        D_rs_addr = 1; E_wa = 1; E_tnew = 2; D_tuse_rs = 1;
        step("reset_hold");
        step("reset_hold2");
        idle_inputs();
        reset = 1'b0;
        step("after_reset");

        // Load-use hazard: one stall, then the bubble has moved on.
        D_rs_addr = 1; D_tuse_rs = 1; E_wa = 1; E_tnew = 2;
        step("lw_use");
        chk("lw_use.stall_lit", 32'(exp_stall_last), 32'd1);
        E_wa = 0; E_tnew = 0; M_wa = 1; M_tnew = 1;
        step("lw_use_after");

        // rt hazard from M with exactly equal Tnew/Tuse is not a stall.
        idle_inputs();
        D_rt_addr = 7; D_tuse_rt = 1; M_wa = 7; M_tnew = 1;
        step("rt_equal");
        M_tnew = 2;
        step("rt_m_greater");

        // $0 is never a hazard.
        idle_inputs();
        D_rs_addr = 0; E_wa = 0; E_tnew = 2; D_tuse_rs = 0;
        step("zero_reg");

        // mult then mfhi held in D: 1+5 stall cycles, 5 busy cycles.
        idle_inputs();
        E_md_start = 1; E_md_div = 0; D_is_md = 1;
        n_busy = 0; n_stall = 0;
        step("mult_start");
        if (exp_stall_last) n_stall++;
        E_md_start = 0;
        for (int i = 0; i < 12; i++) begin
            if (md_busy) n_busy++;
            step("mult_wait");
            if (exp_stall_last) n_stall++;
        end
        chk("mult_busy_cycles", 32'(n_busy), 32'd5);
        chk("mult_stall_cycles", 32'(n_stall), 32'd6);

        // div with req at busy cycle 4: no stall that cycle, no abort.
        idle_inputs();
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        step("div_start");
        E_md_start = 0; E_md_div = 0;
        n_busy = 0;
        for (int i = 1; i <= 14; i++) begin
            req = (i == 4);
            if (md_busy) n_busy++;
            step(i == 4 ? "div_req" : "div_wait");
        end
        chk("div_busy_cycles", 32'(n_busy), 32'd10);

        // Start cancelled by req in the same cycle.
        idle_inputs();
        E_md_start = 1; req = 1; D_is_md = 1;
        step("start_req");
        E_md_start = 0; req = 0;
        step("start_req_next");
        chk("start_req.md_busy_lit", 32'(md_busy), 32'd0);

        // Stall three cycles, then reset in the middle of a div.
        idle_inputs();
        D_rs_addr = 3; E_wa = 3; E_tnew = 3; D_tuse_rs = 0;
        repeat (3) step("stats_stall");
        idle_inputs();
        E_md_start = 1; E_md_div = 1;
        step("rst_div_start");
        E_md_start = 0;
        repeat (3) step("rst_div_run");
        reset = 1;
        step("rst_mid_busy");
        reset = 0;
        step("rst_mid_busy_after");
        chk("rst_mid_busy.md_busy_lit", 32'(md_busy), 32'd0);

        // Random traffic; small register range makes address matches frequent.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            D_rs_addr  = 5'($urandom_range(0, 3));
            D_rt_addr  = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            E_wa       = 5'($urandom_range(0, 3));
            E_tnew     = 2'($urandom_range(0, 3));
            M_wa       = 5'($urandom_range(0, 3));
            M_tnew     = 2'($urandom_range(0, 3));
            D_is_md    = ($urandom_range(0, 2) == 0);
            E_md_start = ($urandom_range(0, 9) == 0);
            E_md_div   = 1'($urandom_range(0, 1));
            req        = ($urandom_range(0, 11) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
